// File: rtl/boot_rom_fetch_if.sv
// Instruction-fetch front end for the boot ROM: fixed one-cycle latency, range checking.
// Define BOOT_ROM_FETCH_BUF_EN to add a one-word buffer of the last ROM read.
module boot_rom_fetch_if #(
  parameter int unsigned ROM_WORDS = 548,
  parameter logic [31:0] BASE_ADDR = 32'h0000_8000
) (
  input  logic        CLK,
  input  logic        RSTN,
  input  logic        instr_req_i,
  input  logic [31:0] instr_addr_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  output logic [31:0] instr_rdata_o,
  output logic        instr_err_o,
  output logic        rom_csn_o,
  output logic [9:0]  rom_addr_o,
  input  logic [31:0] rom_rdata_i
);

  typedef enum logic [1:0] {IDLE, RESP_ROM, RESP_BUF, RESP_ERR} resp_state_e;

  resp_state_e state_q, state_d;
  logic        rvalid_q, rvalid_d;
  logic        err_q, err_d;
  logic [31:0] offset;
  logic [31:0] word_idx;
  logic        in_range;
  logic        hit;

  assign offset   = instr_addr_i - BASE_ADDR;
  assign word_idx = offset >> 2;
  assign in_range = (instr_addr_i >= BASE_ADDR) && (word_idx < ROM_WORDS);

`ifdef BOOT_ROM_FETCH_BUF_EN
  logic        buf_valid_q, buf_valid_d;
  logic [9:0]  buf_tag_q, buf_tag_d;
  logic [31:0] buf_data_q, buf_data_d;
  logic [9:0]  fill_idx_q, fill_idx_d;

  // A fill in flight (RESP_ROM) counts as a hit so the same word is never read twice.
  always_comb begin
    hit = in_range &&
          ((buf_valid_q && (word_idx[9:0] == buf_tag_q)) ||
           ((state_q == RESP_ROM) && (word_idx[9:0] == fill_idx_q)));
    buf_valid_d = buf_valid_q;
    buf_tag_d   = buf_tag_q;
    buf_data_d  = buf_data_q;
    fill_idx_d  = word_idx[9:0];
    if (state_q == RESP_ROM) begin
      buf_valid_d = 1'b1;
      buf_tag_d   = fill_idx_q;
      buf_data_d  = rom_rdata_i;
    end
  end
`else
  assign hit = 1'b0;
`endif

  always_comb begin
    state_d  = IDLE;
    rvalid_d = 1'b0;
    err_d    = 1'b0;
    if (instr_req_i) begin
      rvalid_d = 1'b1;
      if (!in_range) begin
        state_d = RESP_ERR;
        err_d   = 1'b1;
      end else if (hit) begin
        state_d = RESP_BUF;
      end else begin
        state_d = RESP_ROM;
      end
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q     <= IDLE;
      rvalid_q    <= 1'b0;
      err_q       <= 1'b0;
`ifdef BOOT_ROM_FETCH_BUF_EN
      buf_valid_q <= 1'b0;
      buf_tag_q   <= '0;
      buf_data_q  <= '0;
      fill_idx_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      rvalid_q    <= rvalid_d;
      err_q       <= err_d;
`ifdef BOOT_ROM_FETCH_BUF_EN
      buf_valid_q <= buf_valid_d;
      buf_tag_q   <= buf_tag_d;
      buf_data_q  <= buf_data_d;
      fill_idx_q  <= fill_idx_d;
`endif
    end
  end

  assign instr_gnt_o    = instr_req_i;
  assign instr_rvalid_o = rvalid_q;
  assign instr_err_o    = err_q;
  // RSTN gates the select directly so the ROM stays idle throughout reset.
  assign rom_csn_o      = !(RSTN && instr_req_i && in_range && !hit);
  assign rom_addr_o     = word_idx[9:0];

  always_comb begin
    instr_rdata_o = '0;
    case (state_q)
      RESP_ROM: instr_rdata_o = rom_rdata_i;
`ifdef BOOT_ROM_FETCH_BUF_EN
      RESP_BUF: instr_rdata_o = buf_data_q;
`endif
      default: ;
    endcase
  end

endmodule
